// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the elastic pipeline stage register: FSM state
// encoding, per-stage payload widths and the MEM/WB field packing.
package pipe_stage_reg_pkg;

    // Occupancy states of a stage. The encoding doubles as the entry count.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } ps_state_t;

    // Per-stage payload widths and control-field widths. The control field
    // always sits in the low bits, so it can be squashed on a bubble.
    localparam int IFID_W        = 64;   // pc + instruction
    localparam int IFID_CTRL_W   = 0;
    localparam int EXMEM_W       = 72;   // 3 ctrl + alu + store data + rd
    localparam int EXMEM_CTRL_W  = 3;
    localparam int MEMWB_W       = 72;   // 2 mem_to_reg + 1 we + 32 + 32 + 5
    localparam int MEMWB_CTRL_W  = 3;

    // MEM/WB field offsets (LSB positions) for manual packing/unpacking.
    localparam int MEMWB_MEM_TO_REG_LSB = 0;
    localparam int MEMWB_MEM_TO_REG_W   = 2;
    localparam int MEMWB_REG_WE_BIT     = 2;
    localparam int MEMWB_ALU_LSB        = 3;
    localparam int MEMWB_RDATA_LSB      = 35;
    localparam int MEMWB_RD_LSB         = 67;
    localparam int MEMWB_RD_W           = 5;

    // Same MEM/WB packing as a packed struct; first member is the MSB end.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] mem_rdata;
        logic [31:0] alu_result;
        logic        reg_write_en;
        logic [1:0]  mem_to_reg;
    } memwb_t;

    // Number of held entries implied by a state.
    function automatic logic [1:0] state_count(input ps_state_t s);
        logic [1:0] n;
        case (s)
            PS_EMPTY: n = 2'd0;
            PS_ONE:   n = 2'd1;
            PS_TWO:   n = 2'd2;
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_stage_fsm.sv
// Occupancy controller for pipe_stage_reg. Owns the state, the entry count,
// in_ready/out_valid and the load enables that steer the datapath registers.
module pipe_stage_fsm
    import pipe_stage_reg_pkg::*;
#(
    parameter int SKID = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] count,
    output logic       load_main,
    output logic       load_skid,
    output logic       main_from_skid
);

    ps_state_t  r_state;
    ps_state_t  w_state_next;
    logic       r_in_ready;
    logic       r_out_valid;
    logic [1:0] r_count;
    logic       w_in_ready_comb;
    logic       w_in_fire;
    logic       w_out_fire;

    // With a skid entry in_ready comes straight from a flop; without one the
    // stage can accept whenever its single entry is empty or leaving.
    assign w_in_ready_comb = !r_out_valid || out_ready;
    assign in_ready        = (SKID != 0) ? r_in_ready : w_in_ready_comb;
    assign out_valid       = r_out_valid;
    assign count           = r_count;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // Next-state and load-enable decode; flush wins and suppresses every load
    // so the discarded input never reaches the data registers.
    always_comb begin
        w_state_next   = r_state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            w_state_next = PS_EMPTY;
        end else if (SKID != 0) begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_next = PS_ONE;
                        load_main    = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        load_main = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_next = PS_TWO;
                        load_skid    = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_next = PS_EMPTY;
                    end
                end
                PS_TWO: begin
                    // in_ready is low here, so only the output can move.
                    if (w_out_fire) begin
                        w_state_next   = PS_ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_next = PS_EMPTY;
                end
            endcase
        end else begin
            if (w_in_fire) begin
                w_state_next = PS_ONE;
                load_main    = 1'b1;
            end else if (w_out_fire) begin
                w_state_next = PS_EMPTY;
            end
        end
    end

    // State register with all status outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= PS_EMPTY;
            r_out_valid <= 1'b0;
            r_count     <= 2'd0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= (w_state_next != PS_EMPTY);
            r_count     <= state_count(w_state_next);
            r_in_ready  <= (w_state_next != PS_TWO);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake, synchronous flush,
// optional two-entry skid buffer, and control-bit squash on bubbles.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int WIDTH  = MEMWB_W,
    parameter int CTRL_W = MEMWB_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] w_skid;
    logic [WIDTH-1:0] w_main_next;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_main_from_skid;

    pipe_stage_fsm #(
        .SKID (SKID)
    ) u_fsm (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .count          (count),
        .load_main      (w_load_main),
        .load_skid      (w_load_skid),
        .main_from_skid (w_main_from_skid)
    );

    // The head entry is refilled either from upstream or from the skid slot.
    assign w_main_next = w_main_from_skid ? w_skid : in_data;

    // Head register; only written on a load so a stalled output is stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
        end else if (w_load_main || w_main_from_skid) begin
            r_main <= w_main_next;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] r_skid;

            // Second entry, written when upstream pushes into a full head.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_skid <= '0;
                end else if (w_load_skid) begin
                    r_skid <= in_data;
                end
            end

            assign w_skid = r_skid;
        end else begin : g_no_skid
            logic unused_load_skid;
            assign unused_load_skid = w_load_skid;
            assign w_skid           = '0;
        end
    endgenerate

    // Bubble squash: low control bits read as zero whenever nothing is valid,
    // upper payload bits pass through unchanged.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_squash
            if (gi < CTRL_W) begin : g_ctrl
                assign out_data[gi] = r_main[gi] & out_valid;
            end else begin : g_pay
                assign out_data[gi] = r_main[gi];
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance and one single-register
// instance, directed vector table, reset checks and randomized traffic
// compared against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int W = 72;
    localparam logic [W-1:0] CMASK = 72'h7;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic         f1, iv1, or1;
    logic [W-1:0] d1;
    logic         ir1, ov1;
    logic [W-1:0] od1;
    logic [1:0]   c1;

    logic         f0, iv0, or0;
    logic [W-1:0] d0;
    logic         ir0, ov0;
    logic [W-1:0] od0;
    logic [1:0]   c0;

    pipe_stage_reg #(.WIDTH(W), .CTRL_W(3), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(f1), .in_valid(iv1), .in_ready(ir1),
        .in_data(d1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .count(c1)
    );

    pipe_stage_reg #(.WIDTH(W), .CTRL_W(3), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(f0), .in_valid(iv0), .in_ready(ir0),
        .in_data(d0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .count(c0)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents plus the last value that sat at the head.
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];
    logic [W-1:0] h1;
    logic [W-1:0] h0;

    typedef struct {
        bit           mode0;
        bit           fl;
        bit           iv;
        logic [W-1:0] d;
        bit           ordy;
        bit           ev;
        logic [W-1:0] ed;
        logic [1:0]   ec;
        bit           er;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit m0, bit fl, bit iv, logic [W-1:0] d,
                                bit ordy, bit ev, logic [W-1:0] ed,
                                logic [1:0] ec, bit er);
        vec_t v;
        v.mode0 = m0; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.ec = ec; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare both DUTs with the model, then advance one clock and update it.
    task automatic model_step(input bit do_chk);
        bit           ev1, er1, ev0, er0, inf1, outf1, inf0, outf0;
        bit           fl1, fl0;
        logic [W-1:0] ed1, ed0, nd1, nd0;
        ev1 = (q1.size() != 0);
        ed1 = ev1 ? q1[0] : (h1 & ~CMASK);
        er1 = (q1.size() < 2);
        ev0 = (q0.size() != 0);
        ed0 = ev0 ? q0[0] : (h0 & ~CMASK);
        er0 = (q0.size() == 0) || or0;
        if (do_chk) begin
            chk("skid_valid", ov1, ev1);
            chk("skid_data",  od1, ed1);
            chk("skid_count", c1,  q1.size());
            chk("skid_ready", ir1, er1);
            chk("noskid_valid", ov0, ev0);
            chk("noskid_data",  od0, ed0);
            chk("noskid_count", c0,  q0.size());
            chk("noskid_ready", ir0, er0);
        end
        inf1 = iv1 && er1;  outf1 = ev1 && or1; fl1 = f1; nd1 = d1;
        inf0 = iv0 && er0;  outf0 = ev0 && or0; fl0 = f0; nd0 = d0;
        @(posedge clk);
        if (q1.size() != 0) h1 = q1[0];
        if (fl1) q1.delete();
        else begin
            if (outf1) void'(q1.pop_front());
            if (inf1) q1.push_back(nd1);
        end
        if (q1.size() != 0) h1 = q1[0];
        if (q0.size() != 0) h0 = q0[0];
        if (fl0) q0.delete();
        else begin
            if (outf0) void'(q0.pop_front());
            if (inf0) q0.push_back(nd0);
        end
        if (q0.size() != 0) h0 = q0[0];
    endtask

    task automatic idle_inputs();
        f1 = 0; iv1 = 0; or1 = 0; d1 = '0;
        f0 = 0; iv0 = 0; or0 = 0; d0 = '0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_skid_valid"}, ov1, 1'b0);
        chk({tag, "_skid_data"},  od1, '0);
        chk({tag, "_skid_count"}, c1,  2'd0);
        chk({tag, "_skid_ready"}, ir1, 1'b1);
        chk({tag, "_noskid_valid"}, ov0, 1'b0);
        chk({tag, "_noskid_data"},  od0, '0);
        chk({tag, "_noskid_count"}, c0,  2'd0);
        chk({tag, "_noskid_ready"}, ir0, 1'b1);
    endtask

    task automatic clear_model();
        q1.delete(); q0.delete(); h1 = '0; h0 = '0;
    endtask

    initial begin
        idle_inputs();
        d1 = '1; d0 = '1; iv1 = 1; iv0 = 1;
        clear_model();

        // Reset with all-ones input data
        #2 rst = 1'b1;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_inputs();

        // SKID=1: pass-through, backpressure, flush, squash
        tv.push_back(mk(0,0,1,72'h11,1, 0,72'h0,0,1));
        tv.push_back(mk(0,0,1,72'h22,1, 1,72'h11,1,1));
        tv.push_back(mk(0,0,1,72'h33,1, 1,72'h22,1,1));
        tv.push_back(mk(0,0,0,72'h0,1,  1,72'h33,1,1));
        tv.push_back(mk(0,0,0,72'h0,0,  0,72'h30,0,1));
        tv.push_back(mk(0,0,1,72'hA1,0, 0,72'h30,0,1));
        tv.push_back(mk(0,0,1,72'hA2,0, 1,72'hA1,1,1));
        tv.push_back(mk(0,0,1,72'hA3,0, 1,72'hA1,2,0));
        tv.push_back(mk(0,0,1,72'hA3,1, 1,72'hA1,2,0));
        tv.push_back(mk(0,0,1,72'hA3,1, 1,72'hA2,1,1));
        tv.push_back(mk(0,0,0,72'h0,1,  1,72'hA3,1,1));
        tv.push_back(mk(0,0,0,72'h0,0,  0,72'hA0,0,1));
        tv.push_back(mk(0,0,1,72'hB1,0, 0,72'hA0,0,1));
        tv.push_back(mk(0,0,1,72'hB2,0, 1,72'hB1,1,1));
        tv.push_back(mk(0,1,1,72'h55,0, 1,72'hB1,2,0));
        tv.push_back(mk(0,0,0,72'h0,0,  0,72'hB0,0,1));
        tv.push_back(mk(0,0,1,72'hC7,0, 0,72'hB0,0,1));
        tv.push_back(mk(0,1,1,72'h55,1, 1,72'hC7,1,1));
        tv.push_back(mk(0,0,0,72'h0,1,  0,72'hC0,0,1));
        tv.push_back(mk(0,0,1,72'h123456789ABCDEF007,0, 0,72'hC0,0,1));
        tv.push_back(mk(0,0,0,72'h0,1,  1,72'h123456789ABCDEF007,1,1));
        tv.push_back(mk(0,0,0,72'h0,0,  0,72'h123456789ABCDEF000,0,1));
        tv.push_back(mk(0,1,0,72'h0,0,  0,72'h123456789ABCDEF000,0,1));
        tv.push_back(mk(0,0,0,72'h0,0,  0,72'h123456789ABCDEF000,0,1));
        // SKID=0: combinational in_ready, same-cycle refill, flush discard
        tv.push_back(mk(1,0,1,72'h66,0, 0,72'h0,0,1));
        tv.push_back(mk(1,0,1,72'h77,0, 1,72'h66,1,0));
        tv.push_back(mk(1,0,1,72'h77,1, 1,72'h66,1,1));
        tv.push_back(mk(1,0,0,72'h0,0,  1,72'h77,1,0));
        tv.push_back(mk(1,0,0,72'h0,1,  1,72'h77,1,1));
        tv.push_back(mk(1,0,0,72'h0,0,  0,72'h70,0,1));
        tv.push_back(mk(1,1,1,72'h5F,0, 0,72'h70,0,1));
        tv.push_back(mk(1,0,0,72'h0,0,  0,72'h70,0,1));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            idle_inputs();
            if (tv[i].mode0) begin
                f0 = tv[i].fl; iv0 = tv[i].iv; d0 = tv[i].d; or0 = tv[i].ordy;
            end else begin
                f1 = tv[i].fl; iv1 = tv[i].iv; d1 = tv[i].d; or1 = tv[i].ordy;
            end
            #1;
            if (tv[i].mode0) begin
                chk($sformatf("vec%0d_valid", i), ov0, tv[i].ev);
                chk($sformatf("vec%0d_data", i),  od0, tv[i].ed);
                chk($sformatf("vec%0d_count", i), c0,  tv[i].ec);
                chk($sformatf("vec%0d_ready", i), ir0, tv[i].er);
            end else begin
                chk($sformatf("vec%0d_valid", i), ov1, tv[i].ev);
                chk($sformatf("vec%0d_data", i),  od1, tv[i].ed);
                chk($sformatf("vec%0d_count", i), c1,  tv[i].ec);
                chk($sformatf("vec%0d_ready", i), ir1, tv[i].er);
            end
            model_step(1);
        end

        // Reset in the middle of operation with both stages holding data
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle_inputs();
            iv1 = 1; d1 = {8'($urandom), $urandom, $urandom};
            iv0 = 1; d0 = {8'($urandom), $urandom, $urandom};
            #1 model_step(1);
        end
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        #1 check_reset_values("midrst");
        clear_model();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic on both instances
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            f1  = ($urandom_range(0, 19) == 0);
            iv1 = $urandom_range(0, 3) != 0;
            or1 = $urandom_range(0, 2) != 0;
            d1  = {8'($urandom), $urandom, $urandom};
            f0  = ($urandom_range(0, 19) == 0);
            iv0 = $urandom_range(0, 3) != 0;
            or0 = $urandom_range(0, 2) != 0;
            d0  = {8'($urandom), $urandom, $urandom};
            #1 model_step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
